// File: rtl/lifo_buffer_if.sv
// rtl/lifo_buffer_if.sv - command/status bundle between a stack user and lifo_buffer
// Ports (master drives commands, slave drives status):
//   clear, push, pop, data_in            : commands
//   data_out, pop_valid, top, count,
//   empty, full, overflow, underflow     : status
interface lifo_buffer_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
);
    logic                       clear;
    logic                       push;
    logic                       pop;
    logic [WIDTH-1:0]           data_in;
    logic [WIDTH-1:0]           data_out;
    logic                       pop_valid;
    logic [WIDTH-1:0]           top;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       empty;
    logic                       full;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output clear, push, pop, data_in,
        input  data_out, pop_valid, top, count, empty, full, overflow, underflow
    );

    modport slave (
        input  clear, push, pop, data_in,
        output data_out, pop_valid, top, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/lifo_buffer.sv
// rtl/lifo_buffer.sv - parametrised LIFO stack with overflow policy, replace-top and peek
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : lifo_buffer_if.slave (clear/push/pop/data_in in; data_out, pop_valid,
//           top, count, empty, full, overflow, underflow out)
module lifo_buffer #(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 16,
    parameter int OVERWRITE = 1
) (
    input  logic          clock,
    input  logic          reset,
    lifo_buffer_if.slave  bus
);
    localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
    localparam bit             OVR      = (OVERWRITE != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_inc;
    logic [PW-1:0]    ptr_dec;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] data_out_q;
    logic             pop_valid_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             is_empty;
    logic             is_full;
    logic             mem_we;
    logic [PW-1:0]    mem_addr;

    // Explicit wrap so DEPTH need not be a power of two.
    assign ptr_inc  = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    assign ptr_dec  = (ptr == '0) ? PTR_LAST : ptr - 1'b1;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.top       = is_empty ? '0 : mem[ptr_dec];
    assign bus.data_out  = data_out_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    // Replace-top writes the current top slot; a plain push writes the free slot,
    // which on a full stack with overwrite is the oldest entry.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = ptr;
        if (!bus.clear && bus.push) begin
            if (bus.pop) begin
                mem_we   = !is_empty;
                mem_addr = ptr_dec;
            end else begin
                mem_we   = !is_full || OVR;
            end
        end
    end

    // Storage has no reset: entries beyond count are never observed.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= bus.data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            if (bus.clear) begin
                ptr        <= '0;
                count_q    <= '0;
                data_out_q <= '0;
            end else if (bus.push && bus.pop) begin
                pop_valid_q <= 1'b1;
                if (is_empty) begin
                    // Bypass: the pushed word leaves straight away.
                    data_out_q <= bus.data_in;
                end else begin
                    data_out_q <= mem[ptr_dec];
                end
            end else if (bus.push) begin
                if (!is_full) begin
                    ptr     <= ptr_inc;
                    count_q <= count_q + 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                    if (OVR) begin
                        ptr <= ptr_inc;
                    end
                end
            end else if (bus.pop) begin
                if (!is_empty) begin
                    data_out_q  <= mem[ptr_dec];
                    ptr         <= ptr_dec;
                    count_q     <= count_q - 1'b1;
                    pop_valid_q <= 1'b1;
                end else begin
                    underflow_q <= 1'b1;
                end
            end
        end
    end
endmodule
